// File: rtl/pow2_floor_serial_if.sv
// Operand/result handshake bundle for the serial floor-power-of-two normaliser.
interface pow2_floor_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic             out_zero;
    logic             out_exact;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_onehot, out_zero, out_exact
    );

    // Normaliser side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_onehot, out_zero, out_exact
    );
endinterface

// File: rtl/pow2_floor_serial.sv
// Serial normaliser: shifts the operand left until its MSB is set and returns the
// floor power of two as a one-hot word, with zero and exact-power flags.
module pow2_floor_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pow2_floor_serial_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             zero_q, zero_d;
    logic             exact_q, exact_d;

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            zero_q   <= 1'b0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            zero_q   <= zero_d;
            exact_q  <= exact_d;
        end
    end

    // Next-state and result logic; cnt tracks shifts so the one-hot bit is WIDTH-1-cnt.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        zero_d   = zero_q;
        exact_d  = exact_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sreg_q == '0) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    onehot_d = '0;
                    zero_d   = 1'b1;
                    exact_d  = 1'b0;
                end else if (sreg_q[WIDTH-1]) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    onehot_d = WIDTH'(1) << (CW'(WIDTH - 1) - cnt_q);
                    zero_d   = 1'b0;
                    exact_d  = (sreg_q[WIDTH-2:0] == '0);
                end else begin
                    sreg_d = sreg_q << 1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_onehot = onehot_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_exact  = exact_q;
endmodule

// File: tb/tb_pow2_floor_serial.sv
// Directed and randomised-stream bench for pow2_floor_serial.
module tb_pow2_floor_serial;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pow2_floor_serial_if #(.WIDTH(WIDTH)) bus ();

    pow2_floor_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: highest set bit only.
    function automatic logic [WIDTH-1:0] floor_p2(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            if (v[i]) r = '0 | (WIDTH'(1) << i);
        return r;
    endfunction

    // Issue one operand with out_ready high; check result, flags and latency.
    task automatic run_one(input logic [7:0] data, input logic [7:0] exp_oh,
                           input logic exp_zero, input logic exp_exact, input int exp_lat);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        check($sformatf("in_ready before 0x%0h", data), 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency 0x%0h", data), 32'(n + 1), 32'(exp_lat));
        check($sformatf("onehot 0x%0h", data), 32'(bus.out_onehot), 32'(exp_oh));
        check($sformatf("zero 0x%0h", data), 32'(bus.out_zero), 32'(exp_zero));
        check($sformatf("exact 0x%0h", data), 32'(bus.out_exact), 32'(exp_exact));
        @(posedge clk); #1;
        check($sformatf("valid drop 0x%0h", data), 32'(bus.out_valid), 32'd0);
        check($sformatf("ready back 0x%0h", data), 32'(bus.in_ready), 32'd1);
        check($sformatf("onehot kept 0x%0h", data), 32'(bus.out_onehot), 32'(exp_oh));
    endtask

    logic [WIDTH-1:0] expq[$];
    int               received;

    initial begin
        int n;
        bit seen;
        errors        = 0;
        checks        = 0;
        received      = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset onehot", 32'(bus.out_onehot), 32'd0);
        check("reset zero", 32'(bus.out_zero), 32'd0);
        check("reset exact", 32'(bus.out_exact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // Exact powers.
        run_one(8'h01, 8'h01, 1'b0, 1'b1, 9);
        run_one(8'h10, 8'h10, 1'b0, 1'b1, 5);
        run_one(8'h80, 8'h80, 1'b0, 1'b1, 2);
        // Non-powers.
        run_one(8'h03, 8'h02, 1'b0, 1'b0, 8);
        run_one(8'h5A, 8'h40, 1'b0, 1'b0, 3);
        run_one(8'hFF, 8'h80, 1'b0, 1'b0, 2);
        run_one(8'h81, 8'h80, 1'b0, 1'b0, 2);
        // Zero operand.
        run_one(8'h00, 8'h00, 1'b1, 1'b0, 2);
        run_one(8'h81, 8'h80, 1'b0, 1'b0, 2);

        // Reset mid-SHIFT on 0x03 discards the operation.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midop rst out_valid", 32'(bus.out_valid), 32'd0);
        check("midop rst onehot", 32'(bus.out_onehot), 32'd0);
        check("midop rst zero", 32'(bus.out_zero), 32'd0);
        check("midop rst exact", 32'(bus.out_exact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midop rst in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("no result after rst", 32'(seen), 32'd0);

        // Backpressure: 0x24 held in DONE while 0x99 waits.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h24;
        @(posedge clk); #1;
        bus.in_data = 8'h99;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 32'(n + 1), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp onehot %0d", i), 32'(bus.out_onehot), 32'h20);
            check($sformatf("bp in_ready %0d", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        check("bp release valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("0x99 latency", 32'(n + 1), 32'd2);
        check("0x99 onehot", 32'(bus.out_onehot), 32'h80);
        check("0x99 exact", 32'(bus.out_exact), 32'd0);
        @(posedge clk); #1;

        // Random stream with gaps on both sides.
        fork
            begin : producer
                for (int i = 0; i < 50; i++) begin
                    int tries;
                    logic [WIDTH-1:0] v;
                    @(negedge clk);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    v = WIDTH'($urandom);
                    if (i % 10 == 3) v = '0;
                    bus.in_valid = 1'b1;
                    bus.in_data  = v;
                    tries = 0;
                    while (!bus.in_ready && tries < 200) begin
                        @(negedge clk);
                        tries++;
                    end
                    if (tries >= 200) check("stream accept timeout", 32'd1, 32'd0);
                    expq.push_back(v);
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                end
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (received < 50 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        logic [WIDTH-1:0] v;
                        if (expq.size() == 0) begin
                            check("stream unexpected result", 32'(bus.out_onehot), 32'hFFFF);
                        end else begin
                            v = expq.pop_front();
                            check($sformatf("stream onehot %0d", received),
                                  32'(bus.out_onehot), 32'(floor_p2(v)));
                            check($sformatf("stream zero %0d", received),
                                  32'(bus.out_zero), 32'(v == '0));
                            check($sformatf("stream exact %0d", received),
                                  32'(bus.out_exact), 32'(v != '0 && floor_p2(v) == v));
                        end
                        received++;
                        @(posedge clk);
                    end
                end
                if (cyc >= 5000) check("stream timeout", 32'(received), 32'd50);
            end
        join
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("stream no extra result", 32'(seen), 32'd0);
        check("stream count", 32'(received), 32'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
